// File: rtl/risk_control_unit.sv
// risk_control_unit: ID-stage hazard sequencer for load-use stalls, control flushes and HALT drain
module risk_control_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rt,
  input  logic                  i_id_halt,
  input  logic                  i_id_jump,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic                  i_ex_branch_taken,
  output logic                  o_risk,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_ifid_flush,
  output logic                  o_halted,
  output logic [1:0]            o_state,
  output logic [15:0]           o_stall_count
);
  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;
  localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES > 1 ? STALL_CYCLES - 2 : 0);
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
  state_t     state;
  logic [3:0] cnt;
  logic       hz, branch_act, stall_bubble;
  assign hz = i_ex_mem_read & (i_ex_rt != '0) &
              ((i_ex_rt == i_id_rs) | (i_id_uses_rt & (i_ex_rt == i_id_rt)));
  assign branch_act   = i_ex_branch_taken & (state == RUN | state == STALL);
  assign stall_bubble = i_enable & ~i_ex_branch_taken & ((state == RUN & hz) | state == STALL);
  assign o_state  = state;
  assign o_halted = state == HALTED;
  // Mealy pipeline controls: reset bubbles, disable freezes, otherwise by state and priority
  always_comb begin
    o_risk       = 1'b0;
    o_pc_write   = 1'b0;
    o_ifid_write = 1'b0;
    o_ifid_flush = 1'b0;
    if (!i_reset_n) o_risk = 1'b1;
    else if (i_enable) begin
      if (branch_act) {o_risk, o_pc_write, o_ifid_write, o_ifid_flush} = 4'b1111;
      else if (stall_bubble | state == DRAIN | state == HALTED) o_risk = 1'b1;
      else if (i_id_jump) {o_pc_write, o_ifid_write, o_ifid_flush} = 3'b111;
      else if (!i_id_halt) {o_pc_write, o_ifid_write} = 2'b11;
    end
  end
  // Sequencer state, countdown and saturating load-use bubble counter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= RUN;
      cnt           <= '0;
      o_stall_count <= '0;
    end else if (i_enable) begin
      if (stall_bubble && o_stall_count != 16'hFFFF) o_stall_count <= o_stall_count + 16'd1;
      case (state)
        RUN: begin
          if (!i_ex_branch_taken && hz && STALL_CYCLES > 1) begin
            state <= STALL;
            cnt   <= STALL_INIT;
          end else if (!i_ex_branch_taken && !hz && !i_id_jump && i_id_halt) begin
            state <= DRAIN;
            cnt   <= DRAIN_INIT;
          end
        end
        STALL: begin
          if (i_ex_branch_taken || cnt == '0) state <= RUN;
          else cnt <= cnt - 4'd1;
        end
        DRAIN: begin
          if (cnt == '0) state <= HALTED;
          else cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_risk_control_unit.sv
// tb_risk_control_unit: directed scoreboard bench for the hazard sequencer (STALL_CYCLES 1 and 3)
module tb_risk_control_unit;
  logic       clk = 1'b0;
  logic       reset_n, enable, uses_rt, halt, jump, mem_read, branch;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       risk_a, pcw_a, ifw_a, flush_a, halted_a;
  logic       risk_b, pcw_b, ifw_b, flush_b, halted_b;
  logic [1:0] state_a, state_b;
  logic [15:0] cnt_a, cnt_b;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {string tag; logic [15:0] exp;} sb_t;
  sb_t q[$];

  always #5 clk = ~clk;

  risk_control_unit #(.REG_ADDR_W(5), .STALL_CYCLES(1), .DRAIN_CYCLES(4)) dut_a (
    .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rt(uses_rt), .i_id_halt(halt), .i_id_jump(jump), .i_ex_mem_read(mem_read),
    .i_ex_rt(ex_rt), .i_ex_branch_taken(branch), .o_risk(risk_a), .o_pc_write(pcw_a),
    .o_ifid_write(ifw_a), .o_ifid_flush(flush_a), .o_halted(halted_a), .o_state(state_a),
    .o_stall_count(cnt_a));

  risk_control_unit #(.REG_ADDR_W(5), .STALL_CYCLES(3), .DRAIN_CYCLES(4)) dut_b (
    .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rt(uses_rt), .i_id_halt(halt), .i_id_jump(jump), .i_ex_mem_read(mem_read),
    .i_ex_rt(ex_rt), .i_ex_branch_taken(branch), .o_risk(risk_b), .o_pc_write(pcw_b),
    .o_ifid_write(ifw_b), .o_ifid_flush(flush_b), .o_halted(halted_b), .o_state(state_b),
    .o_stall_count(cnt_b));

  // control vectors packed as {risk, pc_write, ifid_write, flush}; status as {halted, state}
  wire [15:0] ctl_a = {12'b0, risk_a, pcw_a, ifw_a, flush_a};
  wire [15:0] ctl_b = {12'b0, risk_b, pcw_b, ifw_b, flush_b};
  wire [15:0] st_a  = {13'b0, halted_a, state_a};
  wire [15:0] st_b  = {13'b0, halted_b, state_b};

  task automatic push(input string tag, input logic [15:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    q.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    sb_t e;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h required an entry", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    enable = 1'b1; uses_rt = 1'b0; halt = 1'b0; jump = 1'b0; mem_read = 1'b0; branch = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    push("reset_ctl", 16'h8); push("reset_st", 16'h0); push("reset_cnt", 16'h0);
    #2;
    chk(ctl_a); chk(st_a); chk(cnt_a);
    #1 reset_n = 1'b1;
    step();
    push("idle_ctl", 16'h6);
    #2 chk(ctl_a);

    mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    push("lu_rs_a", 16'h8); push("lu_rs_b", 16'h8);
    #2 chk(ctl_a); chk(ctl_b);
    step(); idle();
    push("lu_a_state", 16'h0); push("lu_a_cnt", 16'h1); push("lu_b_state", 16'h1); push("lu_b_cnt", 16'h1);
    chk(st_a); chk(cnt_a); chk(st_b); chk(cnt_b);
    push("lu_a_after", 16'h6); push("lu_b_stall1", 16'h8);
    #2 chk(ctl_a); chk(ctl_b);
    step();
    push("lu_b_cnt2", 16'h2); push("lu_b_stall2", 16'h8);
    chk(cnt_b); #2 chk(ctl_b);
    step();
    push("lu_b_back", 16'h0); push("lu_b_cnt3", 16'h3); push("lu_b_run", 16'h6);
    chk(st_b); chk(cnt_b); #2 chk(ctl_b);

    mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    push("r0_nohz", 16'h6);
    #2 chk(ctl_a);
    ex_rt = 5'd7; id_rt = 5'd7; uses_rt = 1'b0;
    push("rt_unused", 16'h6);
    #2 chk(ctl_a);
    step(); idle();

    branch = 1'b1; mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; halt = 1'b1;
    push("br_prio_a", 16'hF); push("br_prio_b", 16'hF);
    #2 chk(ctl_a); chk(ctl_b);
    step(); idle();
    push("br_st_a", 16'h0); push("br_cnt_a", 16'h1); push("br_st_b", 16'h0); push("br_cnt_b", 16'h3);
    chk(st_a); chk(cnt_a); chk(st_b); chk(cnt_b);

    jump = 1'b1;
    push("jump_ctl", 16'h7);
    #2 chk(ctl_a);
    step(); idle();
    push("jump_st", 16'h0);
    chk(st_a);

    mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; uses_rt = 1'b1;
    push("en_hz_b", 16'h8);
    #2 chk(ctl_b);
    step(); idle();
    push("en_cnt4", 16'h4); push("en_st1", 16'h1);
    chk(cnt_b); chk(st_b);
    enable = 1'b0;
    push("dis_ctl_b", 16'h0); push("dis_ctl_a", 16'h0);
    #2 chk(ctl_b); chk(ctl_a);
    step();
    push("dis_hold_st", 16'h1); push("dis_hold_cnt", 16'h4);
    chk(st_b); chk(cnt_b);
    step();
    enable = 1'b1;
    push("en_hold_cnt", 16'h4); push("re_en_bubble", 16'h8);
    chk(cnt_b); #2 chk(ctl_b);
    step();
    push("stall_cnt5", 16'h5); push("stall_last", 16'h8);
    chk(cnt_b); #2 chk(ctl_b);
    step();
    push("stall_cnt6", 16'h6); push("stall_done_st", 16'h0);
    chk(cnt_b); chk(st_b);

    halt = 1'b1;
    push("halt_decode", 16'h0);
    #2 chk(ctl_a);
    step(); idle();
    for (int i = 0; i < 4; i++) begin
      push("drain_st", 16'h2); push("drain_ctl", 16'h8);
      chk(st_a); #2 chk(ctl_a);
      step();
    end
    push("halted_st", 16'h7); push("halted_b_st", 16'h7);
    chk(st_a); chk(st_b);
    jump = 1'b1; branch = 1'b1;
    push("halted_ignore", 16'h8);
    #2 chk(ctl_a);
    enable = 1'b0;
    push("halted_dis_ctl", 16'h0);
    #2 chk(ctl_a);
    step();
    push("halted_dis_st", 16'h7);
    chk(st_a);
    idle();

    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    step();
    halt = 1'b1;
    step(); idle();
    step();
    push("pre_rst_drain", 16'h2);
    chk(st_a);
    #2 reset_n = 1'b0;
    push("rst_mid_st", 16'h0); push("rst_mid_ctl", 16'h8); push("rst_mid_cnt", 16'h0);
    #1 chk(st_a); chk(ctl_a); chk(cnt_a);
    #2 reset_n = 1'b1;
    step();
    push("post_rst_ctl", 16'h6); push("post_rst_st", 16'h0);
    #2 chk(ctl_a); chk(st_a);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/risk_control_unit.md
# risk_control_unit

Pipeline hazard sequencer for the five-stage MIPS core. Sits in ID beside the control unit and drives the bubble-select input of the control-signal mux (`i_risk`), the PC and IF/ID write enables, and the IF/ID flush. It handles load-use stalls, control-transfer flushes and the HALT drain, and it keeps a saturating count of load-use stall cycles for the debug unit.

## Interface
- `REG_ADDR_W`, 5: register-address width.
- `STALL_CYCLES`, 1: bubbles inserted per load-use hazard; legal range 1..3.
- `DRAIN_CYCLES`, 4: cycles held in drain after HALT is decoded; legal range 1..15.

- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_reset_n`  in  1  reset; asynchronous, active-low.
- `i_enable`  in  1  debug-unit run/step enable; 0 freezes the pipeline and this block's state.
- `i_id_rs`  in  REG_ADDR_W  rs field of the IF/ID instruction.
- `i_id_rt`  in  REG_ADDR_W  rt field of the IF/ID instruction.
- `i_id_uses_rt`  in  1  IF/ID instruction reads rt as a source.
- `i_id_halt`  in  1  IF/ID instruction is HALT (from the control unit).
- `i_id_jump`  in  1  jump resolved in ID (J/JAL/JR/JALR).
- `i_ex_mem_read`  in  1  ID/EX instruction is a load.
- `i_ex_rt`  in  REG_ADDR_W  load destination register in ID/EX.
- `i_ex_branch_taken`  in  1  branch resolved taken in EX.
- `o_risk`  out  1  insert bubble into ID/EX; drives the control mux select.
- `o_pc_write`  out  1  PC register write enable.
- `o_ifid_write`  out  1  IF/ID register write enable.
- `o_ifid_flush`  out  1  clear IF/ID to NOP on the next edge.
- `o_halted`  out  1  pipeline drained after HALT.
- `o_state`  out  2  FSM state, for the debug unit: RUN=0, STALL=1, DRAIN=2, HALTED=3.
- `o_stall_count`  out  16  saturating count of load-use bubble cycles.

## Operation
- Hazard term: `hz = i_ex_mem_read & (i_ex_rt != 0) & ((i_ex_rt == i_id_rs) | (i_id_uses_rt & i_ex_rt == i_id_rt))`.
- Priority in RUN: `i_ex_branch_taken` > `hz` > `i_id_jump` > `i_id_halt`.
- RUN behaviour:
  - Branch taken: `o_risk=1`, `o_ifid_flush=1`, `o_pc_write=1`, `o_ifid_write=1`. Any HALT, hazard or jump in IF/ID is on the wrong path and is ignored.
  - `hz`: `o_risk=1`, `o_pc_write=0`, `o_ifid_write=0`. If `STALL_CYCLES>1`, go to STALL with `cnt=STALL_CYCLES-2`; otherwise stay in RUN.
  - `i_id_jump`: `o_ifid_flush=1`. PC and IF/ID write enabled; `o_risk=0`, because the jump itself proceeds.
  - `i_id_halt`: `o_pc_write=0`, `o_ifid_write=0`, `o_risk=0`. The HALT proceeds to EX. Go to DRAIN with `cnt=DRAIN_CYCLES-1`.
  - Otherwise: `o_pc_write=1`, `o_ifid_write=1`, `o_risk=0`, `o_ifid_flush=0`.
- STALL: outputs as for `hz`, regardless of `hz`. Decrement `cnt`; at `cnt==0` return to RUN. A taken branch in STALL aborts to RUN with the branch-taken outputs.
- DRAIN:
  - `o_pc_write=0`, `o_ifid_write=0`, `o_risk=1`.
  - Decrement `cnt`; at `cnt==0` go to HALTED.
  - Branch and jump inputs are ignored.
- HALTED: same outputs as DRAIN, plus `o_halted=1`. HALTED is terminal; only reset exits it.
- `i_enable=0`:
  - `o_pc_write=0`, `o_ifid_write=0`, `o_ifid_flush=0`, `o_risk=0`.
  - FSM, `cnt` and `o_stall_count` hold.
  - In HALTED, `o_halted` stays 1.
- `o_stall_count` increments by 1 for each enabled cycle in which `o_risk=1` is caused by `hz` or by the STALL state. It saturates at 16'hFFFF.

## Timing
- Async reset (`i_reset_n=0`) forces the following immediately, independent of the clock:
  - state=RUN, `cnt=0`, `o_stall_count=0`, `o_halted=0`, `o_state=0`;
  - `o_pc_write=0`, `o_ifid_write=0`, `o_ifid_flush=0`, `o_risk=1`.
- Reset deassertion takes effect on the next edge. Reset mid-STALL or mid-DRAIN discards the sequence.
- All outputs other than `o_halted`, `o_state` and `o_stall_count` are Mealy: combinational from state and inputs, same cycle. No registered latency.
- `o_halted`, `o_state` and `o_stall_count` are registered and update on the edge after the causing cycle.
- Load-use: the hazard cycle plus `STALL_CYCLES-1` STALL cycles gives exactly `STALL_CYCLES` bubbles and frozen cycles.
- HALT: the decode cycle, then `DRAIN_CYCLES` DRAIN cycles, then HALTED. `o_halted` rises on edge `DRAIN_CYCLES+1` after the decode cycle.

## Test plan
- Load-use on rs: `i_ex_mem_read=1`, `i_ex_rt=5`, `i_id_rs=5`, `STALL_CYCLES=1` -> one cycle with `o_risk=1`, `o_pc_write=0`, `o_ifid_write=0`, then RUN; `o_stall_count` 0->1.
- No hazard on r0, or rt unused: `i_ex_rt=0`, `i_id_rs=0` -> `o_risk=0`. Then `i_ex_rt=7`, `i_id_rt=7`, `i_id_uses_rt=0` -> `o_risk=0`, `o_pc_write=1`.
- Branch priority: `i_ex_branch_taken=1` together with `hz=1` and `i_id_halt=1` -> `o_risk=1`, `o_ifid_flush=1`, `o_pc_write=1`; state stays RUN and no stall is counted.
- HALT drain, `DRAIN_CYCLES=4`: pulse `i_id_halt` -> `o_state` goes 2, then 3 after 4 further cycles; `o_halted=1`; `o_pc_write` stays 0 thereafter, even with `i_id_jump=1`.
- `STALL_CYCLES=3` with `i_enable` dropped for 2 cycles mid-stall -> exactly 3 enabled bubble cycles in total; outputs all 0 except `o_halted` while disabled; `o_stall_count=3`.
- Reset mid-DRAIN: assert `i_reset_n=0` asynchronously -> `o_state=0`, `o_halted=0`, `o_risk=1`, `o_pc_write=0` immediately; normal RUN after release.
